// File: rtl/shift_out16_pkg.sv
// Shared types and helpers for the shift_out16 serializer.
// Optional parity framing is selected by the SHIFT_OUT16_PARITY_EN macro.
package shift_out16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_out16_bit_counter.sv
// Clearable up-counter that flags the cycle carrying the last data bit of a word.
module shift_out16_bit_counter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // count_reg equals the index of the bit currently on the serial line.
    assign last = (count_reg == LAST_COUNT);

endmodule

// File: rtl/shift_out16.sv
// Serializes one WIDTH-bit word per valid/ready handshake, LSB first, with frame and done strobes.
// Define SHIFT_OUT16_PARITY_EN to append an even-parity bit to every frame.
module shift_out16
    import shift_out16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic             ser_out_reg;
    logic             ser_frame_reg;
    logic             done_reg;
    logic             bit_last;
    logic             cnt_clear;
    logic             cnt_inc;
`ifdef SHIFT_OUT16_PARITY_EN
    logic             parity_reg;
`endif

    assign load_ready = (state_reg == IDLE);
    assign cnt_clear  = load_valid && load_ready;
    assign cnt_inc    = (state_reg == SHIFT);

    assign ser_out   = ser_out_reg;
    assign ser_frame = ser_frame_reg;
    assign done      = done_reg;

    shift_out16_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (bit_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            ser_out_reg   <= 1'b0;
            ser_frame_reg <= 1'b0;
            done_reg      <= 1'b0;
`ifdef SHIFT_OUT16_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ser_out_reg   <= 1'b0;
                    ser_frame_reg <= 1'b0;
                    if (load_valid) begin
                        // Bit 0 goes straight to the output register, so the
                        // shift register only keeps the remaining bits.
                        shreg_reg     <= {1'b0, load_data[WIDTH-1:1]};
                        ser_out_reg   <= load_data[0];
                        ser_frame_reg <= 1'b1;
                        state_reg     <= SHIFT;
`ifdef SHIFT_OUT16_PARITY_EN
                        parity_reg    <= ^load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (bit_last) begin
`ifdef SHIFT_OUT16_PARITY_EN
                        ser_out_reg   <= parity_reg;
                        ser_frame_reg <= 1'b1;
                        state_reg     <= PARITY;
`else
                        ser_out_reg   <= 1'b0;
                        ser_frame_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= IDLE;
`endif
                    end else begin
                        ser_out_reg <= shreg_reg[0];
                        shreg_reg   <= shreg_reg >> 1;
                    end
                end
`ifdef SHIFT_OUT16_PARITY_EN
                PARITY: begin
                    ser_out_reg   <= 1'b0;
                    ser_frame_reg <= 1'b0;
                    done_reg      <= 1'b1;
                    state_reg     <= IDLE;
                end
`endif
                default: begin
                    ser_out_reg   <= 1'b0;
                    ser_frame_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule
